// File: rtl/riscoffee_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : riscoffee_wb_arbiter
// Purpose : Round-robin arbiter sharing the single register-file write port
//           between NREQ writeback requesters (ALU, load unit, mul/div, ...).
//           Each requester uses a valid/ready handshake; the write port is
//           driven from registers one cycle after the handshake.
//           With RIP_WB_SCOREBOARD_EN defined, a busy bit per architectural
//           register tracks in-flight destinations for decode hazard checks.
// Ports   : CLK, RST_N        clock, synchronous active-low reset
//           REQ_VALID/READY   per-requester handshake (READY is one-hot grant)
//           REQ_RD/REQ_DATA   packed per-requester rd number and write data
//           WB_WEN/RD/WDATA   registered register-file write port
//           CLAIM_VALID/RD    issue-stage destination claim (scoreboard)
//           Q_RS1/Q_RS2       decode source-register busy query
//           BUSY_RS1/BUSY_RS2 source has an outstanding, unwritten result
// Config  : RIP_WB_SCOREBOARD_EN - enables busy-register scoreboard
// Revision: 1.0 - initial release
// ============================================================================
module riscoffee_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 32
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [NREQ-1:0]      REQ_VALID,
  output logic [NREQ-1:0]      REQ_READY,
  input  logic [NREQ*5-1:0]    REQ_RD,
  input  logic [NREQ*XLEN-1:0] REQ_DATA,
  output logic                 WB_WEN,
  output logic [4:0]           WB_RD,
  output logic [XLEN-1:0]      WB_WDATA,
  input  logic                 CLAIM_VALID,
  input  logic [4:0]           CLAIM_RD,
  input  logic [4:0]           Q_RS1,
  input  logic [4:0]           Q_RS2,
  output logic                 BUSY_RS1,
  output logic                 BUSY_RS2
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]   ptr_q, ptr_d;
  logic            wen_q, wen_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] wdata_q, wdata_d;

  logic [NREQ-1:0] w_hi;        // valid requesters at or above the pointer
  logic [NREQ-1:0] w_hi_pick;
  logic [NREQ-1:0] w_lo_pick;
  logic [NREQ-1:0] w_gnt;
  logic [PW-1:0]   w_gnt_idx;
  logic [4:0]      w_sel_rd;
  logic [XLEN-1:0] w_sel_data;

  // Round-robin as two priority passes: the lowest valid index >= ptr wins;
  // if none exists the search wraps, i.e. the lowest valid index overall.
  for (genvar g = 0; g < NREQ; g++) begin : g_hi_mask
    assign w_hi[g] = REQ_VALID[g] & (PW'(g) >= ptr_q);
  end

  // x & -x isolates the lowest set bit.
  assign w_hi_pick = w_hi & (~w_hi + NREQ'(1));
  assign w_lo_pick = REQ_VALID & (~REQ_VALID + NREQ'(1));
  assign w_gnt     = !RST_N ? '0 : ((|w_hi) ? w_hi_pick : w_lo_pick);
  assign REQ_READY = w_gnt;

  // One-hot grant -> index and write-data select.
  always_comb begin
    w_gnt_idx  = '0;
    w_sel_rd   = '0;
    w_sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_gnt_idx  = PW'(i);
        w_sel_rd   = REQ_RD[5*i +: 5];
        w_sel_data = REQ_DATA[XLEN*i +: XLEN];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (|w_gnt) begin
      ptr_d = (w_gnt_idx == PW'(NREQ-1)) ? '0 : w_gnt_idx + PW'(1);
    end
  end

  // Writes to x0 still complete the handshake but never reach the port;
  // rd/data only change when a real write is launched.
  always_comb begin
    wen_d   = (|w_gnt) && (w_sel_rd != 5'd0);
    rd_d    = wen_d ? w_sel_rd   : rd_q;
    wdata_d = wen_d ? w_sel_data : wdata_q;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ptr_q   <= '0;
      wen_q   <= 1'b0;
      rd_q    <= '0;
      wdata_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      wen_q   <= wen_d;
      rd_q    <= rd_d;
      wdata_q <= wdata_d;
    end
  end

  assign WB_WEN   = wen_q;
  assign WB_RD    = rd_q;
  assign WB_WDATA = wdata_q;

`ifdef RIP_WB_SCOREBOARD_EN
  logic [31:1] busy_q, busy_d;
  logic [31:0] w_busy_full;
  logic [31:0] w_busy_next;

  // Bit 0 is a hard zero so x0 is never reported busy.
  assign w_busy_full = {busy_q, 1'b0};

  // Clear first, then set: a claim landing with the retiring write of the
  // same rd belongs to a newer instruction and must survive.
  always_comb begin
    w_busy_next = w_busy_full;
    if (wen_q) begin
      w_busy_next[rd_q] = 1'b0;
    end
    if (CLAIM_VALID && (CLAIM_RD != 5'd0)) begin
      w_busy_next[CLAIM_RD] = 1'b1;
    end
    busy_d = w_busy_next[31:1];
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // The register file forwards a same-cycle write, so the retiring rd is
  // not a hazard even though its busy bit is still set this cycle.
  assign BUSY_RS1 = w_busy_full[Q_RS1] & ~(wen_q && (rd_q == Q_RS1));
  assign BUSY_RS2 = w_busy_full[Q_RS2] & ~(wen_q && (rd_q == Q_RS2));
`else
  logic w_unused_ok;
  assign w_unused_ok = ^{CLAIM_VALID, CLAIM_RD, Q_RS1, Q_RS2};
  assign BUSY_RS1    = 1'b0;
  assign BUSY_RS2    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_riscoffee_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_riscoffee_wb_arbiter
// Purpose : Self-checking bench for riscoffee_wb_arbiter (NREQ=3, XLEN=32).
//           Stimulus pushes cycle-tagged expectations into queues; a monitor
//           on the falling edge pops and compares grants, write-port activity
//           and busy flags every cycle.
// Revision: 1.0 - initial release
// ============================================================================
module tb_riscoffee_wb_arbiter;

  localparam int NREQ = 3;
  localparam int XLEN = 32;
`ifdef RIP_WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RST_N;
  logic [NREQ-1:0]   REQ_VALID;
  logic [NREQ-1:0]   REQ_READY;
  logic [NREQ*5-1:0] REQ_RD;
  logic [NREQ*XLEN-1:0] REQ_DATA;
  logic              WB_WEN;
  logic [4:0]        WB_RD;
  logic [XLEN-1:0]   WB_WDATA;
  logic              CLAIM_VALID;
  logic [4:0]        CLAIM_RD;
  logic [4:0]        Q_RS1;
  logic [4:0]        Q_RS2;
  logic              BUSY_RS1;
  logic              BUSY_RS2;

  logic [4:0]        rd_s  [NREQ];
  logic [XLEN-1:0]   dat_s [NREQ];

  assign REQ_RD   = {rd_s[2], rd_s[1], rd_s[0]};
  assign REQ_DATA = {dat_s[2], dat_s[1], dat_s[0]};

  riscoffee_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .REQ_VALID   (REQ_VALID),
    .REQ_READY   (REQ_READY),
    .REQ_RD      (REQ_RD),
    .REQ_DATA    (REQ_DATA),
    .WB_WEN      (WB_WEN),
    .WB_RD       (WB_RD),
    .WB_WDATA    (WB_WDATA),
    .CLAIM_VALID (CLAIM_VALID),
    .CLAIM_RD    (CLAIM_RD),
    .Q_RS1       (Q_RS1),
    .Q_RS2       (Q_RS2),
    .BUSY_RS1    (BUSY_RS1),
    .BUSY_RS2    (BUSY_RS2)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct { int cyc; logic [NREQ-1:0] g; }                gnt_t;
  typedef struct { int cyc; logic [4:0] rd; logic [XLEN-1:0] d; } wb_t;
  typedef struct { int cyc; logic b; }                           busy_t;

  gnt_t  q_gnt[$];
  wb_t   q_wb[$];
  busy_t q_busy[$];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One cycle of stimulus: drive valids and claim, queue the expected grant,
  // the resulting write (next cycle, suppressed for x0) and busy flag value.
  task automatic step(input logic [NREQ-1:0] v, input logic [NREQ-1:0] g,
                      input logic cv, input logic [4:0] crd, input logic eb);
    gnt_t  eg;
    wb_t   ew;
    busy_t ebz;
    REQ_VALID   = v;
    CLAIM_VALID = cv;
    CLAIM_RD    = crd;
    eg.cyc = cyc; eg.g = g;
    q_gnt.push_back(eg);
    for (int i = 0; i < NREQ; i++) begin
      if (g[i] && rd_s[i] != 5'd0) begin
        ew.cyc = cyc + 1; ew.rd = rd_s[i]; ew.d = dat_s[i];
        q_wb.push_back(ew);
      end
    end
    ebz.cyc = cyc; ebz.b = eb & SB;
    q_busy.push_back(ebz);
    tick();
  endtask

  // Monitor: compares every post-reset cycle against the queued expectations.
  always @(negedge CLK) begin
    if (RST_N === 1'b1) begin
      if (q_gnt.size() > 0 && q_gnt[0].cyc == cyc) begin
        gnt_t e;
        e = q_gnt.pop_front();
        chk("grant", 64'(REQ_READY), 64'(e.g));
      end
      if (q_wb.size() > 0 && q_wb[0].cyc == cyc) begin
        wb_t e;
        e = q_wb.pop_front();
        chk("wb_wen",   64'(WB_WEN),   64'd1);
        chk("wb_rd",    64'(WB_RD),    64'(e.rd));
        chk("wb_wdata", 64'(WB_WDATA), 64'(e.d));
      end else begin
        chk("wb_idle", 64'(WB_WEN), 64'd0);
      end
      if (q_busy.size() > 0 && q_busy[0].cyc == cyc) begin
        busy_t e;
        e = q_busy.pop_front();
        chk("busy_rs1", 64'(BUSY_RS1), 64'(e.b));
        chk("busy_rs2", 64'(BUSY_RS2), 64'(e.b));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    RST_N       = 1'b0;
    REQ_VALID   = '1;
    CLAIM_VALID = 1'b0;
    CLAIM_RD    = '0;
    Q_RS1       = '0;
    Q_RS2       = '0;
    for (int i = 0; i < NREQ; i++) begin
      rd_s[i]  = 5'(10 + i);
      dat_s[i] = 32'hA000_0000 + 32'(i);
    end

    // Reset held with every requester valid.
    repeat (3) begin
      @(posedge CLK);
      @(negedge CLK);
      chk("rst_ready", 64'(REQ_READY), 64'd0);
      chk("rst_wen",   64'(WB_WEN),    64'd0);
      chk("rst_rd",    64'(WB_RD),     64'd0);
      chk("rst_wdata", 64'(WB_WDATA),  64'd0);
    end
    tick();
    RST_N = 1'b1;

    // Fairness: all valid -> 0,1,2,0,1,2 with six back-to-back writes.
    step(3'b111, 3'b001, 1'b0, 5'd0, 1'b0);
    step(3'b111, 3'b010, 1'b0, 5'd0, 1'b0);
    step(3'b111, 3'b100, 1'b0, 5'd0, 1'b0);
    step(3'b111, 3'b001, 1'b0, 5'd0, 1'b0);
    step(3'b111, 3'b010, 1'b0, 5'd0, 1'b0);
    step(3'b111, 3'b100, 1'b0, 5'd0, 1'b0);
    step(3'b000, 3'b000, 1'b0, 5'd0, 1'b0);

    // Single request from requester 1.
    rd_s[1]  = 5'd5;
    dat_s[1] = 32'hDEAD_BEEF;
    step(3'b010, 3'b010, 1'b0, 5'd0, 1'b0);
    step(3'b000, 3'b000, 1'b0, 5'd0, 1'b0);
    step(3'b000, 3'b000, 1'b0, 5'd0, 1'b0);

    // x0 write: handshake completes, no write, pointer moves to 1.
    rd_s[0]  = 5'd0;
    dat_s[0] = 32'h0000_1234;
    step(3'b001, 3'b001, 1'b0, 5'd0, 1'b0);
    step(3'b111, 3'b010, 1'b0, 5'd0, 1'b0);
    step(3'b111, 3'b100, 1'b0, 5'd0, 1'b0);
    step(3'b111, 3'b001, 1'b0, 5'd0, 1'b0);
    step(3'b000, 3'b000, 1'b0, 5'd0, 1'b0);

    // Partial valid patterns with wrap-around (pointer starts at 1).
    rd_s[0]  = 5'd3;
    dat_s[0] = 32'h0000_0333;
    step(3'b101, 3'b100, 1'b0, 5'd0, 1'b0);
    step(3'b110, 3'b010, 1'b0, 5'd0, 1'b0);
    step(3'b011, 3'b001, 1'b0, 5'd0, 1'b0);
    step(3'b000, 3'b000, 1'b0, 5'd0, 1'b0);

    // Scoreboard: claim, retire, re-claim in the retiring cycle (pointer at 1).
    Q_RS1 = 5'd7;
    Q_RS2 = 5'd7;
    step(3'b000, 3'b000, 1'b1, 5'd7, 1'b0);
    step(3'b000, 3'b000, 1'b0, 5'd0, 1'b1);
    rd_s[2]  = 5'd7;
    dat_s[2] = 32'h0000_0077;
    step(3'b100, 3'b100, 1'b0, 5'd0, 1'b1);
    step(3'b000, 3'b000, 1'b1, 5'd7, 1'b0);
    rd_s[0]  = 5'd7;
    dat_s[0] = 32'h0000_0088;
    step(3'b001, 3'b001, 1'b0, 5'd0, 1'b1);
    step(3'b000, 3'b000, 1'b0, 5'd0, 1'b0);
    step(3'b000, 3'b000, 1'b0, 5'd0, 1'b0);
    step(3'b000, 3'b000, 1'b1, 5'd0, 1'b0);
    Q_RS1 = 5'd0;
    Q_RS2 = 5'd0;
    step(3'b000, 3'b000, 1'b0, 5'd0, 1'b0);

    REQ_VALID = '0;
    repeat (3) tick();
    chk("queues_drained", 64'(q_gnt.size() + q_wb.size() + q_busy.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
